// File: rtl/mult16_seq.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock,
// WIDTH iterations per request, product delivered on registered hi/lo.
module mult16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [2*WIDTH:0]   product_reg, product_next, product_step;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [WIDTH:0]     upper_sum;

    // The product MSB is always zero entering a step (previous shift zero-filled
    // it), so adding into the full upper WIDTH+1 bits keeps the carry exactly.
    always_comb begin
        upper_sum = product_reg[2*WIDTH:WIDTH];
        if (product_reg[0]) begin
            upper_sum = product_reg[2*WIDTH:WIDTH] + {1'b0, mcand_reg};
        end
        product_step = {upper_sum, product_reg[WIDTH-1:0]} >> 1;
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        product_next = product_reg;
        mcand_next   = mcand_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = RUN;
                    mcand_next   = multiplicand;
                    product_next = {1'b0, {WIDTH{1'b0}}, multiplier};
                    count_next   = '0;
                end
            end
            RUN: begin
                product_next = product_step;
                count_next   = count_reg + CW'(1);
                if (count_reg == LAST_ITER) begin
                    state_next = DONE;
                    hi_next    = product_step[2*WIDTH-1:WIDTH];
                    lo_next    = product_step[WIDTH-1:0];
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            product_reg <= '0;
            mcand_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            product_reg <= product_next;
            mcand_reg   <= mcand_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign busy  = (state_reg == RUN);
    assign ready = (state_reg == DONE);
endmodule

// File: tb/tb_mult16_seq.sv
// Directed and randomised checks of mult16_seq: results, latency, busy/ready
// handshake, ignored starts, mid-run reset and back-to-back requests.
module tb_mult16_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        busy;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] prev_result;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
    } vec_t;
    vec_t vecs [6];

    mult16_seq #(.WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .ready        (ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a negedge with the DUT idle. poke_k >= 0 asserts a
    // stray 7x7 start for one cycle at that point of the run.
    task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input int poke_k, input string tag);
        int k;
        int busy_cnt;
        start = 1'b1;
        multiplicand = a;
        multiplier = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        multiplicand = 16'($urandom);
        multiplier = 16'($urandom);
        @(negedge clock);
        k = 0;
        busy_cnt = 0;
        while (!ready && k < 40) begin
            if (busy) busy_cnt++;
            check({tag, " hold"}, {hi, lo}, prev_result);
            if (k == poke_k) begin
                start = 1'b1;
                multiplicand = 16'd7;
                multiplier = 16'd7;
            end else if (k == poke_k + 1) begin
                start = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        start = 1'b0;
        check({tag, " latency"}, k, 16);
        check({tag, " busy_cycles"}, busy_cnt, 16);
        check({tag, " excl"}, {31'd0, busy & ready}, 32'd0);
        check({tag, " result"}, {hi, lo}, exp);
        $display("mult %s: 0x%04h x 0x%04h -> hi=0x%04h lo=0x%04h (latency %0d)", tag, a, b, hi, lo, k);
        @(negedge clock);
        check({tag, " ready_pulse"}, {30'd0, busy, ready}, 32'd0);
        check({tag, " result_held"}, {hi, lo}, exp);
        prev_result = exp;
    endtask

    initial begin
        int ready_cnt;
        int r_idx;
        int r_at [2];
        logic [15:0] ra, rb;

        vecs[0] = '{16'd3,    16'd5,    16'h0000, 16'h000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001};
        vecs[2] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[4] = '{16'd300,  16'd200,  16'h0000, 16'hEA60};
        vecs[5] = '{16'h8000, 16'h0002, 16'h0001, 16'h0000};

        reset = 1'b1;
        start = 1'b0;
        multiplicand = 16'h0;
        multiplier = 16'h0;
        prev_result = 32'h0;
        #1;
        check("reset outputs", {hi, lo}, 32'h0);
        check("reset flags", {30'd0, busy, ready}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_mult(vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo}, -10, $sformatf("vec%0d", i));
        end

        // Stray start with new operands while busy must be ignored.
        do_mult(16'h00FF, 16'h0100, 32'h0000FF00, 5, "ignore_busy");
        ready_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (ready) ready_cnt++;
        end
        check("ignore_busy extra_ready", ready_cnt, 0);

        // Mid-run reset: outputs clear immediately, no ready afterwards.
        start = 1'b1;
        multiplicand = 16'h8000;
        multiplier = 16'h0002;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midreset outputs", {hi, lo}, 32'h0);
        check("midreset flags", {30'd0, busy, ready}, 32'd0);
        $display("reset asserted mid-run: hi=0x%04h lo=0x%04h busy=%0b ready=%0b", hi, lo, busy, ready);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        prev_result = 32'h0;
        ready_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (ready | busy) ready_cnt++;
        end
        check("midreset no_activity", ready_cnt, 0);
        do_mult(16'h8000, 16'h0002, 32'h00010000, -10, "after_reset");

        // Start held high: accepts at E0 and E18 only.
        start = 1'b1;
        multiplicand = 16'd300;
        multiplier = 16'd200;
        @(posedge clock);
        r_idx = 0;
        r_at[0] = -1;
        r_at[1] = -1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clock);
            if (ready) begin
                if (r_idx < 2) begin
                    r_at[r_idx] = k;
                    check($sformatf("b2b result%0d", r_idx), {hi, lo}, 32'h0000EA60);
                    $display("b2b ready %0d at edge E%0d: hi=0x%04h lo=0x%04h", r_idx, k, hi, lo);
                end
                r_idx++;
            end
            if (k == 17) check("b2b idle_after_done", {31'd0, busy}, 32'd0);
            if (k == 18) check("b2b accept_E18", {31'd0, busy}, 32'd1);
            if (k == 19) start = 1'b0;
        end
        check("b2b ready_count", r_idx, 2);
        check("b2b first_ready", r_at[0], 16);
        check("b2b second_ready", r_at[1], 34);
        prev_result = 32'h0000EA60;

        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'hFFFF;
            if (i == 1) rb = 16'h0001;
            do_mult(ra, rb, {16'd0, ra} * {16'd0, rb}, -10, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult16_seq.md
# mult16_seq

Iterative 16×16 unsigned shift-add multiplier that sits directly downstream of the decode/control stage of the single-cycle 16-bit MIPS core and feeds the hi/lo write path. The control unit pulses `start` when a `mult` instruction is decoded, and `busy` drives the core's instruction-stall select. `ready` marks the cycle in which `hi`/`lo` hold the new product and may be written to the hi (r14) and lo (r13) registers.

## Interface
- `WIDTH`, default 16: operand width; product is 2×`WIDTH` bits split into `hi`/`lo`.
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiply; sampled on rising edge, honoured only in IDLE.
- `multiplicand`  in  WIDTH  operand A; latched on accepted `start`.
- `multiplier`  in  WIDTH  operand B; latched on accepted `start`.
- `hi`  out  WIDTH  upper half of last completed product.
- `lo`  out  WIDTH  lower half of last completed product.
- `busy`  out  1  high while iterating; drives instruction stall.
- `ready`  out  1  one-cycle pulse: `hi`/`lo` just updated.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when the iteration counter reaches `WIDTH`.
  - DONE → IDLE unconditionally after one cycle.
- Accepted start:
  - multiplicand register ← `multiplicand`.
  - product register (2×`WIDTH`+1 bits) ← {1'b0, `WIDTH`'b0, `multiplier`}.
  - counter ← 0.
- Each RUN cycle:
  - if product[0]=1, upper `WIDTH`+1 bits ← upper `WIDTH` bits + multiplicand, with carry kept in the MSB; otherwise upper bits unchanged.
  - Whole product register then shifts right by 1, zero-filling the MSB.
  - counter increments.
- Exactly `WIDTH` iterations are performed; there is no early termination, including for zero operands.
- On the RUN→DONE edge: `hi` ← product[2W-1:W], `lo` ← product[W-1:0].
- `hi`/`lo` are registered outputs. They hold their previous values throughout RUN and change only on the RUN→DONE edge.
- `busy` = (state==RUN). `ready` = (state==DONE). Both are decoded from registered state; no combinational path from inputs.
- `start` is ignored in RUN and DONE: no queuing, and operands are not re-latched.
- Operands may change after the accepting edge without affecting the result.
- Arithmetic is unsigned only; the result is exact modulo 2^(2W), with no overflow possible.

## Timing
- Reset (async assert, any state):
  - state=IDLE, counter=0, product/multiplicand regs=0.
  - `hi`=0, `lo`=0, `busy`=0, `ready`=0, all immediately.
- Reset mid-RUN aborts the operation: no `ready` pulse, and `hi`/`lo` return to 0.
- Reset release is synchronous-safe: the first edge after deassertion may accept `start`.
- Call the edge that samples `start` in IDLE E0.
  - `busy` is high from after E0 through E16. Iterations run on E1..E16.
  - `hi`/`lo` update at E16.
  - `ready` is high for the single cycle between E16 and E17.
  - Back in IDLE after E17.
- Latency from the accepting edge to `ready`: `WIDTH` cycles.
- Minimum start-to-start spacing: `WIDTH`+2 cycles. The earliest next accept is E18, because `start` sampled at E17 is in DONE and is ignored.
- The core must hold its stall while `busy`=1 and write hi/lo when `ready`=1. `busy` and `ready` are never both high.

## Test plan
- Reset, then `start` with 3×5:
  - `busy` high for 16 cycles.
  - `ready` pulses exactly once, 16 cycles after the accepting edge.
  - `hi`=0x0000, `lo`=0x000F.
  - `hi`/`lo` remain 0 until that edge.
- 0xFFFF×0xFFFF → `hi`=0xFFFE, `lo`=0x0001. Then 0x1234×0x0000 → `hi`=0, `lo`=0, and latency is still 16 cycles.
- Run 0x00FF×0x0100, then while `busy` pulse `start` with 7×7 and change operands:
  - Result is `hi`=0x0000, `lo`=0xFF00.
  - Only one `ready` pulse occurs.
  - The 7×7 request is ignored.
- Start 0x8000×0x0002, then assert `reset` at iteration 8:
  - Outputs are 0 immediately, and no `ready` pulse follows.
  - After release, 0x8000×0x0002 → `hi`=0x0001, `lo`=0x0000.
- Back-to-back requests: hold `start`=1 continuously with 300×200.
  - Accepts occur at E0 and E18, with `ready` pulses 18 cycles apart.
  - `hi`=0x0000, `lo`=0xEA60 each time.
  - `start` during DONE is confirmed ignored.
- Randomised 500 operand pairs against a reference product, checking:
  - `hi`:`lo` equals the reference product.
  - `busy`/`ready` are mutually exclusive.
  - `hi`/`lo` are stable outside the DONE-entry edge.
